// File: rtl/clk_tick_gen.sv
// Run-time programmable tick generator: one-cycle tick every D enabled cycles,
// a toggling clk_out and a postscaled slow tick, all as enables on clock_i.
module clk_tick_gen #(
   parameter int CNT_W       = 25,
   parameter int DEFAULT_DIV = 500000,
   parameter int POST_W      = 7,
   parameter int POST_DIV    = 100
) (
   input  logic             clock_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             div_load_i,
   input  logic [CNT_W-1:0] div_value_i,
   output logic             tick_o,
   output logic             tick_slow_o,
   output logic             clk_out_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             div_pending_o,
   output logic             div_err_o
);

   logic [CNT_W-1:0]  div_cur_q, div_cur_d;
   logic [CNT_W-1:0]  div_nxt_q, div_nxt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [POST_W-1:0] post_q, post_d;
   logic              pend_q, pend_d;
   logic              clk_out_q, clk_out_d;
   logic              tick_q, tick_d;
   logic              slow_q, slow_d;
   logic              err_q, err_d;

   logic load_ok;
   logic wrap;

   assign load_ok = div_load_i && (div_value_i >= CNT_W'(2));
   assign wrap    = (cnt_q == div_cur_q - CNT_W'(1));

   always_comb begin
      div_cur_d = div_cur_q;
      div_nxt_d = div_nxt_q;
      cnt_d     = cnt_q;
      post_d    = post_q;
      pend_d    = pend_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      slow_d    = 1'b0;
      err_d     = div_load_i && !load_ok;

      if (clr_i) begin
         cnt_d     = '0;
         post_d    = '0;
         clk_out_d = 1'b0;
         if (load_ok) begin
            div_cur_d = div_value_i;
            pend_d    = 1'b0;
         end else if (pend_q) begin
            div_cur_d = div_nxt_q;
            pend_d    = 1'b0;
         end
      end else if (en_i) begin
         if (wrap) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
            if (post_q == POST_W'(POST_DIV - 1)) begin
               post_d = '0;
               slow_d = 1'b1;
            end else begin
               post_d = post_q + POST_W'(1);
            end
            // A load on the wrap edge is newer than any pending value.
            if (load_ok) begin
               div_cur_d = div_value_i;
               pend_d    = 1'b0;
            end else if (pend_q) begin
               div_cur_d = div_nxt_q;
               pend_d    = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (load_ok) begin
               div_nxt_d = div_value_i;
               pend_d    = 1'b1;
            end
         end
      end else if (load_ok) begin
         div_cur_d = div_value_i;
         cnt_d     = '0;
         pend_d    = 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_cur_q <= CNT_W'(DEFAULT_DIV);
         div_nxt_q <= '0;
         cnt_q     <= '0;
         post_q    <= '0;
         pend_q    <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         slow_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         div_cur_q <= div_cur_d;
         div_nxt_q <= div_nxt_d;
         cnt_q     <= cnt_d;
         post_q    <= post_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         slow_q    <= slow_d;
         err_q     <= err_d;
      end
   end

   assign tick_o        = tick_q;
   assign tick_slow_o   = slow_q;
   assign clk_out_o     = clk_out_q;
   assign cnt_o         = cnt_q;
   assign div_pending_o = pend_q;
   assign div_err_o     = err_q;

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised, fully synchronous successor to the ripple clock divider. It divides `clock` by a divisor that can be changed at run time, without glitches, and produces three outputs: a one-cycle `tick` enable, a 50 %-duty `clk_out` toggle, and a cascaded `tick_slow` enable (post-divided). It sits between the board clock and the stopwatch counting and display logic. All downstream logic stays on `clock` and uses the ticks as enables.

## Interface
- `CNT_W`, 25: width of the main counter and of the divisor.
- `DEFAULT_DIV`, 500000: divisor loaded at reset. Legal range is 2 to 2^CNT_W-1.
- `POST_W`, 7: width of the postscaler counter.
- `POST_DIV`, 100: number of ticks per `tick_slow`. Legal range is 1 to 2^POST_W-1.
- `clock`  in  1  the single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; when low, all counters hold.
- `clr`  in  1  synchronous clear of the counters (the stopwatch "reset" button).
- `div_load`  in  1  one-cycle request to load `div_value`.
- `div_value`  in  CNT_W  requested divisor D.
- `tick`  out  1  one-cycle pulse, once every D enabled cycles.
- `tick_slow`  out  1  one-cycle pulse, once every POST_DIV ticks.
- `clk_out`  out  1  toggles on every tick; period is 2·D cycles.
- `cnt`  out  CNT_W  current main counter value.
- `div_pending`  out  1  a loaded divisor is waiting for the next wrap.
- `div_err`  out  1  one-cycle pulse when a load was rejected.

## Operation
- Registers:
  - `div_cur`: active divisor.
  - `div_nxt`: pending divisor, with the `div_pending` flag.
  - `cnt`: 0 to D-1.
  - `post_cnt`: 0 to POST_DIV-1.
  - `clk_out`, `tick`, `tick_slow`, `div_err`.
- Reset (`rst`=0, asynchronous):
  - `div_cur`=DEFAULT_DIV.
  - `cnt`, `post_cnt`, `tick`, `tick_slow`, `clk_out`, `div_pending`, `div_err` = 0.
- Priority on each edge: `clr`, then `en`, then hold.
- `clr`=1:
  - `cnt`, `post_cnt`, `clk_out` ← 0; `tick`, `tick_slow` ← 0.
  - A pending divisor is applied now: `div_cur`←`div_nxt`, and `div_pending`←0.
- `en`=1 and `cnt` < D-1: `cnt`←`cnt`+1; `tick`←0.
- `en`=1 and `cnt`=D-1 (wrap):
  - `cnt`←0, `tick`←1, `clk_out`←~`clk_out`.
  - `post_cnt` increments modulo POST_DIV.
  - `tick_slow`←1 only if `post_cnt` was POST_DIV-1.
- `en`=0: `cnt`, `post_cnt`, `clk_out` hold; `tick`, `tick_slow` ← 0.
- Divisor load (`div_load`=1):
  - `div_value` < 2: rejected. `div_err`←1 for one cycle; no state change.
  - `en`=0 or `clr`=1: `div_cur`←`div_value` and `cnt`←0 on that edge.
  - `en`=1, not a wrap edge: `div_nxt`←`div_value` and `div_pending`←1. A later load overwrites `div_nxt` (last one wins).
  - `en`=1 on a wrap edge: `div_cur`←`div_value` directly, taking effect for the next period. Any older pending value is discarded; `div_pending`←0.
- At any wrap with `div_pending`=1: `div_cur`←`div_nxt`; `div_pending`←0.
- D is never changed mid-period while counting, so `clk_out` has no runt half-period.
- All arithmetic is unsigned, CNT_W bits. The wrap is detected by equality with `div_cur`-1; there is no overflow path.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `tick` rises on the edge where `cnt` returns to 0, and is high exactly one cycle.
- From reset release with `en`=1, the first `tick` is high after D edges.
- `tick_slow` is coincident with every POST_DIV-th `tick`. It is never high without `tick`.
- After `en` falls, `tick` and `tick_slow` are 0 from the next edge. When `en` rises again, counting resumes from the held `cnt`.
- A valid load while `en`=0 takes effect on the edge it is sampled. `div_err` is high in the cycle after the bad load.
- `rst` asserted mid-period clears everything immediately, with no clock edge needed, and discards any pending divisor.

## Test plan
Bench parameters: CNT_W=8, DEFAULT_DIV=4, POST_DIV=3.
- Reset release, `en`=1 held: `tick` high at edges 4, 8, 12; `tick_slow` at edge 12; `clk_out` reads 1, 0, 1 after those edges; `cnt` sequence 1,2,3,0.
- `en`=0 for 5 cycles at `cnt`=2: `cnt` holds 2; `tick`=0 throughout; `tick` fires 2 edges after `en` returns.
- Load `div_value`=6 at `cnt`=1 with `en`=1: `div_pending`=1; the current period still wraps at 4; the following period wraps after 6 edges; `div_pending`=0 after that wrap.
- Load `div_value`=1, then 0: `div_err` pulses once per load; the period stays 4; `div_pending` stays 0.
- `clr` at `cnt`=3 with `post_cnt`=2: next `cnt`=0, `clk_out`=0, and no `tick` on that edge; the next `tick_slow` comes only after 3 full ticks.
- `rst` pulsed low mid-period with a divisor pending: outputs go to their reset values asynchronously; the period is 4 again; `div_pending`=0.
